// File: rtl/key_matrix_responder.sv
// -----------------------------------------------------------------------------
// key_matrix_responder
//   Device-side stand-in for a 4x4 active-low matrix keypad. A keypad scanner
//   drives the row lines; this block answers on the col lines as a real keypad
//   would. It presses one key per command, with pseudo-random contact chatter
//   after the press and release edges.
//
// Ports
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous reset, active-low (sync release)
//   row        in   4       scanner row drive, active-low (row[r]=0 selects row r)
//   col        out  4       column return, active-low, idle 4'b1111 (registered)
//   cmd_valid  in   1       press command valid
//   cmd_ready  out  1       high while IDLE (command can be accepted)
//   cmd_key    in   4       key index: row = cmd_key[3:2], column = cmd_key[1:0]
//   cmd_hold   in   HOLD_W  extra cycles of clean contact (HOLD lasts cmd_hold+1)
//   busy       out  1       command in progress
//   done       out  1       one-cycle pulse when release chatter completes
// -----------------------------------------------------------------------------
module key_matrix_responder #(
  parameter int          BOUNCE_CYC = 64,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          HOLD_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done
);

  // Elaboration-time parameter checks.
  if (BOUNCE_CYC < 1) begin : g_bad_bounce_cyc
    $error("key_matrix_responder: BOUNCE_CYC must be at least 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_lfsr_seed
    $error("key_matrix_responder: LFSR_SEED must be non-zero");
  end

  localparam int BC_W  = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam int CNT_W = (HOLD_W > BC_W) ? HOLD_W : BC_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS_B = 2'd1,
    HOLD    = 2'd2,
    REL_B   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [15:0]        lfsr, lfsr_nx;
  logic [3:0]         key_q, key_nx;
  logic [HOLD_W-1:0]  hold_q, hold_nx;
  logic               contact, contact_nx;
  logic               done_nx;
  logic [3:0]         col_nx;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Next-state, counter and contact decode. The LFSR steps once for every
  // chatter cycle it supplies, so each bounce phase consumes BOUNCE_CYC bits.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lfsr_nx    = lfsr;
    key_nx     = key_q;
    hold_nx    = hold_q;
    contact_nx = contact;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        contact_nx = 1'b0;
        if (cmd_valid) begin
          state_nx   = PRESS_B;
          cnt_nx     = CNT_W'(BOUNCE_CYC - 1);
          key_nx     = cmd_key;
          hold_nx    = cmd_hold;
          contact_nx = lfsr[0];
          lfsr_nx    = lfsr_step(lfsr);
        end else begin
          state_nx = IDLE;
        end
      end
      PRESS_B: begin
        if (cnt == '0) begin
          state_nx   = HOLD;
          cnt_nx     = CNT_W'(hold_q);
          contact_nx = 1'b1;
        end else begin
          cnt_nx     = cnt - CNT_W'(1);
          contact_nx = lfsr[0];
          lfsr_nx    = lfsr_step(lfsr);
        end
      end
      HOLD: begin
        // Clean contact lasts exactly hold_q+1 cycles; chatter starts on REL_B entry.
        if (cnt == '0) begin
          state_nx   = REL_B;
          cnt_nx     = CNT_W'(BOUNCE_CYC - 1);
          contact_nx = lfsr[0];
          lfsr_nx    = lfsr_step(lfsr);
        end else begin
          cnt_nx     = cnt - CNT_W'(1);
          contact_nx = 1'b1;
        end
      end
      REL_B: begin
        if (cnt == '0) begin
          state_nx   = IDLE;
          contact_nx = 1'b0;
          done_nx    = 1'b1;
        end else begin
          cnt_nx     = cnt - CNT_W'(1);
          contact_nx = lfsr[0];
          lfsr_nx    = lfsr_step(lfsr);
        end
      end
      default: begin
        state_nx   = IDLE;
        contact_nx = 1'b0;
      end
    endcase
  end

  // Column return: only the latched key's row/column pair can pull a line low.
  always_comb begin
    col_nx = 4'b1111;
    if (contact && (row[key_q[3:2]] == 1'b0)) begin
      col_nx[key_q[1:0]] = 1'b0;
    end else begin
      col_nx = 4'b1111;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lfsr    <= LFSR_SEED;
      key_q   <= 4'd0;
      hold_q  <= '0;
      contact <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lfsr    <= lfsr_nx;
      key_q   <= key_nx;
      hold_q  <= hold_nx;
      contact <= contact_nx;
    end
  end

  // Registered outputs; ready/busy follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= 4'b1111;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      col       <= col_nx;
      cmd_ready <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_key_matrix_responder.sv
// -----------------------------------------------------------------------------
// tb_key_matrix_responder
//   Directed, table-driven bench for key_matrix_responder with BOUNCE_CYC=4.
//   Expected behaviour comes from the command timeline: accept at cycle 0,
//   chatter cycles 0..B-1, clean contact B..B+hold, chatter B+hold+1..2B+hold,
//   done at 2B+hold+1; col shows the contact of the previous cycle. Chatter
//   bits are the LSBs of the reference LFSR sequence starting at the seed.
// -----------------------------------------------------------------------------
module tb_key_matrix_responder;

  localparam int          B      = 4;
  localparam int          HW     = 24;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    row;
  logic [3:0]    col;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_key;
  logic [HW-1:0] cmd_hold;
  logic          busy;
  logic          done;

  key_matrix_responder #(.BOUNCE_CYC(B), .LFSR_SEED(SEED), .HOLD_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
    .cmd_hold(cmd_hold), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         hold;
    logic [3:0] row;
    logic [3:0] exp_col;  // col during clean contact
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference timeline state
  logic [15:0] tb_lfsr;
  logic        pb [B];
  logic        rb [B];
  logic        have_cmd;
  logic [3:0]  cur_key;
  int          cur_hold;
  int          k;
  logic        prev_contact;
  logic [3:0]  prev_row;
  logic        acc_evt;

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [3:0] fcol(input logic c, input logic [3:0] r, input logic [3:0] key);
    logic [3:0] v;
    v = 4'b1111;
    if (c && !r[key[3:2]]) v[key[1:0]] = 1'b0;
    return v;
  endfunction

  function automatic logic exp_contact();
    if (!have_cmd) return 1'b0;
    if (k < B) return pb[k];
    if (k <= B + cur_hold) return 1'b1;
    if (k <= 2 * B + cur_hold) return rb[k - B - cur_hold - 1];
    return 1'b0;
  endfunction

  function automatic logic exp_busy();
    return have_cmd && (k <= 2 * B + cur_hold);
  endfunction

  function automatic logic exp_done();
    return have_cmd && (k == 2 * B + cur_hold + 1);
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s t=%0t k=%0d: got %b, expected %b", nm, $time, k, act, expv);
    end
  endtask

  task automatic check_all();
    check("col",   col,               fcol(prev_contact, prev_row, cur_key));
    check("busy",  {3'b000, busy},      {3'b000, exp_busy()});
    check("done",  {3'b000, done},      {3'b000, exp_done()});
    check("ready", {3'b000, cmd_ready}, {3'b000, !exp_busy()});
  endtask

  // Advance one clock and update the reference timeline.
  task automatic tick();
    logic acc;
    acc          = cmd_valid && !exp_busy();
    prev_contact = exp_contact();
    prev_row     = row;
    @(posedge clk);
    #1;
    if (acc) begin
      have_cmd = 1'b1;
      cur_key  = cmd_key;
      cur_hold = int'(cmd_hold);
      k        = 0;
      acc_evt  = 1'b1;
      for (int i = 0; i < B; i++) begin pb[i] = tb_lfsr[0]; tb_lfsr = ref_step(tb_lfsr); end
      for (int i = 0; i < B; i++) begin rb[i] = tb_lfsr[0]; tb_lfsr = ref_step(tb_lfsr); end
    end else begin
      k++;
    end
  endtask

  task automatic issue(input logic [3:0] key, input int hold);
    cmd_key   = key;
    cmd_hold  = HW'(hold);
    cmd_valid = 1'b1;
    acc_evt   = 1'b0;
    check_all();
    tick();
    cmd_valid = 1'b0;
    check("accept", {3'b000, acc_evt}, 4'b0001);
  endtask

  task automatic run_to_end();
    for (int g = 0; g < 2000 && have_cmd && k <= 2 * B + cur_hold + 1; g++) begin
      check_all();
      tick();
    end
  endtask

  vec_t tv [7];
  int   hits;

  initial begin
    tv[0] = '{key: 4'd6,  hold: 100, row: 4'b1101, exp_col: 4'b1011};
    tv[1] = '{key: 4'd0,  hold: 0,   row: 4'b1110, exp_col: 4'b1110};
    tv[2] = '{key: 4'd9,  hold: 3,   row: 4'b1011, exp_col: 4'b1101};
    tv[3] = '{key: 4'd3,  hold: 2,   row: 4'b1101, exp_col: 4'b1111};
    tv[4] = '{key: 4'd12, hold: 1,   row: 4'b0000, exp_col: 4'b1110};
    tv[5] = '{key: 4'd10, hold: 2,   row: 4'b1111, exp_col: 4'b1111};
    tv[6] = '{key: 4'd15, hold: 5,   row: 4'b0110, exp_col: 4'b0111};

    rst_n = 1'b0; row = 4'b1111; cmd_valid = 1'b0; cmd_key = 4'd0; cmd_hold = '0;
    have_cmd = 1'b0; cur_key = 4'd0; cur_hold = 0; k = 0; tb_lfsr = SEED;
    prev_contact = 1'b0; prev_row = 4'b1111; acc_evt = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_col",   col,               4'b1111);
    check("rst_ready", {3'b000, cmd_ready}, 4'b0001);
    check("rst_busy",  {3'b000, busy},      4'b0000);
    check("rst_done",  {3'b000, done},      4'b0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    prev_row = row;
    check_all();

    // Table of single commands, each run through to the done pulse
    for (int i = 0; i < 7; i++) begin
      row = tv[i].row;
      issue(tv[i].key, tv[i].hold);
      for (int g = 0; g < 2000 && k <= 2 * B + cur_hold + 1; g++) begin
        if (k == B + 1 || k == B + cur_hold + 1)
          check("hold_col", col, tv[i].exp_col);
        check_all();
        tick();
      end
    end

    // Scan rotation during HOLD of key 15
    row = 4'b1111;
    issue(4'd15, 20);
    hits = 0;
    for (int g = 0; g < 200 && k <= 2 * B + cur_hold + 1; g++) begin
      check_all();
      if (k >= B + 2 && k <= B + 9 && col == 4'b0111) hits++;
      if (k >= B + 1 && k <= B + 8) begin
        case ((k - B - 1) % 4)
          0:       row = 4'b1110;
          1:       row = 4'b1101;
          2:       row = 4'b1011;
          default: row = 4'b0111;
        endcase
      end else begin
        row = 4'b1111;
      end
      tick();
    end
    check("scan_hits", 4'(hits), 4'd2);

    // cmd_valid while busy is ignored; re-issue taken on the done cycle
    row = 4'b1101;
    issue(4'd7, 5);
    for (int g = 0; g < 2; g++) begin check_all(); tick(); end
    cmd_key = 4'd0; cmd_hold = '0; cmd_valid = 1'b1; acc_evt = 1'b0;
    for (int g = 0; g < 100 && !acc_evt; g++) begin
      if (done) check("b2b_ready", {3'b000, cmd_ready}, 4'b0001);
      check_all();
      tick();
    end
    cmd_valid = 1'b0;
    check("b2b_accept", {3'b000, acc_evt}, 4'b0001);
    check("b2b_busy",   {3'b000, busy},    4'b0001);
    check("b2b_key",    cur_key,           4'd0);
    run_to_end();

    // Reset in the middle of HOLD
    row = 4'b1101;
    issue(4'd5, 50);
    for (int g = 0; g < 10; g++) begin check_all(); tick(); end
    check("pre_rst_col", col, 4'b1101);
    rst_n = 1'b0;
    #1;
    check("mid_rst_col",   col,               4'b1111);
    check("mid_rst_ready", {3'b000, cmd_ready}, 4'b0001);
    check("mid_rst_busy",  {3'b000, busy},      4'b0000);
    check("mid_rst_done",  {3'b000, done},      4'b0000);
    have_cmd = 1'b0; tb_lfsr = SEED; prev_contact = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    prev_row = row;
    for (int g = 0; g < 60; g++) begin check_all(); tick(); end

    // After reset the chatter sequence restarts from the seed
    row = 4'b1101;
    issue(4'd6, 2);
    run_to_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
